// File: rtl/chrarb_pkg.sv
// chrarb_pkg: shared FSM states, requester indices and defaults for the character-ROM arbiter
package chrarb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int NREQ = 3;
  localparam logic [1:0] REQ_BG0 = 2'd0;
  localparam logic [1:0] REQ_BG1 = 2'd1;
  localparam logic [1:0] REQ_SPR = 2'd2;
  localparam int TMO_DEF = 255;
  function automatic logic [1:0] nxt(input logic [1:0] i);
    return i == REQ_SPR ? REQ_BG0 : i + 2'd1;
  endfunction
endpackage

// File: rtl/chrrom_arbiter_if.sv
// chrrom_arbiter_if: character-ROM memory port (req/ad out, ack/dt back); master = arbiter, slave = ROM controller
interface chrrom_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 24
);
  logic req;
  logic [AW-1:0] ad;
  logic ack;
  logic [DW-1:0] dt;
  modport master (output req, ad, input ack, dt);
  modport slave (input req, ad, output ack, dt);
endinterface

// File: rtl/chrarb_pick.sv
// chrarb_pick: combinational 3-way winner picker; round-robin from last grant when CHRARB_RR_EN, else BG0 > BG1 > SPR
// Ports: req (request vector), last (previous grant, round-robin only), gnt (winner index), gv (any request)
module chrarb_pick import chrarb_pkg::*; (
  input logic [NREQ-1:0] req,
`ifdef CHRARB_RR_EN
  input logic [1:0] last,
`endif
  output logic [1:0] gnt,
  output logic gv
);
`ifdef CHRARB_RR_EN
  logic [1:0] s1, s2;
  always_comb begin
    s1 = nxt(last);
    s2 = nxt(s1);
    gnt = req[s1] ? s1 : req[s2] ? s2 : last;
  end
`else
  always_comb gnt = req[REQ_BG0] ? REQ_BG0 : req[REQ_BG1] ? REQ_BG1 : REQ_SPR;
`endif
  assign gv = |req;
endmodule

// File: rtl/chrrom_arbiter.sv
// chrrom_arbiter: shares one variable-latency character-ROM port between BG0, BG1 and sprite requesters
// Ports: VCLKx8/RESET (sync, active high); reqN/adN held requests; rdyN one-cycle completion, dtN held data;
// err sticky timeout flag; mem is the ROM port (master). Macro CHRARB_RR_EN selects round-robin arbitration.
module chrrom_arbiter import chrarb_pkg::*; #(
  parameter int AW = 16,
  parameter int DW = 24,
  parameter int TMO = TMO_DEF
) (
  input logic VCLKx8,
  input logic RESET,
  input logic req0,
  input logic req1,
  input logic req2,
  input logic [AW-1:0] ad0,
  input logic [AW-1:0] ad1,
  input logic [AW-1:0] ad2,
  output logic rdy0,
  output logic rdy1,
  output logic rdy2,
  output logic [DW-1:0] dt0,
  output logic [DW-1:0] dt1,
  output logic [DW-1:0] dt2,
  output logic err,
  chrrom_arbiter_if.master mem
);
  state_t state;
  logic [1:0] gnt, pick;
  logic gv, fin;
  logic [2:0] rdy;
  logic [7:0] cnt;
  logic [AW-1:0] pick_ad;
  logic [DW-1:0] fin_dt;
  // gnt keeps the last winner between transactions, so it doubles as the round-robin pointer
  chrarb_pick u_pick (
    .req({req2, req1, req0}),
`ifdef CHRARB_RR_EN
    .last(gnt),
`endif
    .gnt(pick),
    .gv(gv)
  );
  assign pick_ad = pick == REQ_BG0 ? ad0 : pick == REQ_BG1 ? ad1 : ad2;
  // ack beats a coincident timeout; a timeout returns all ones
  assign fin = mem.ack || cnt == 8'(TMO);
  assign fin_dt = mem.ack ? mem.dt : '1;
  assign {rdy2, rdy1, rdy0} = rdy;
  always_ff @(posedge VCLKx8) begin
    if (RESET) begin
      state <= IDLE;
      mem.req <= 1'b0;
      mem.ad <= '0;
      rdy <= '0;
      dt0 <= '0;
      dt1 <= '0;
      dt2 <= '0;
      err <= 1'b0;
      cnt <= '0;
      gnt <= REQ_SPR;
    end else begin
      rdy <= '0;
      case (state)
        IDLE: if (gv) begin
          gnt <= pick;
          mem.req <= 1'b1;
          mem.ad <= pick_ad;
          cnt <= '0;
          state <= BUSY;
        end
        BUSY: if (fin) begin
          mem.req <= 1'b0;
          rdy <= 3'b001 << gnt;
          err <= err | ~mem.ack;
          state <= DONE;
          if (gnt == REQ_BG0) dt0 <= fin_dt;
          if (gnt == REQ_BG1) dt1 <= fin_dt;
          if (gnt == REQ_SPR) dt2 <= fin_dt;
        end else cnt <= cnt + {7'd0, cnt != 8'hFF};
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_chrrom_arbiter.sv
// tb_chrrom_arbiter: transaction-level model plus directed scenarios for chrrom_arbiter
module tb_chrrom_arbiter;
  localparam int TMO = 10;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] req = '0;
  logic [15:0] ad [3];
  logic [2:0] rdy;
  logic [23:0] dt0, dt1, dt2;
  logic err;
  int lat = 0;
  int bn = 0;
  logic force_ack = 1'b0;
  logic mem_fixed = 1'b0;
  logic [23:0] mem_val = '0;
  int tests = 0;
  int fails = 0;
  chrrom_arbiter_if #(.AW(16), .DW(24)) mem_if ();
  chrrom_arbiter #(.AW(16), .DW(24), .TMO(TMO)) dut (
    .VCLKx8(clk), .RESET(rst),
    .req0(req[0]), .req1(req[1]), .req2(req[2]),
    .ad0(ad[0]), .ad1(ad[1]), .ad2(ad[2]),
    .rdy0(rdy[0]), .rdy1(rdy[1]), .rdy2(rdy[2]),
    .dt0(dt0), .dt1(dt1), .dt2(dt2),
    .err(err), .mem(mem_if)
  );
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // memory: acks on the lat-th cycle of a held request (lat 0 = never); force_ack injects stray acks
  always @(negedge clk) begin
    #1;
    bn = mem_if.req ? bn + 1 : 0;
    mem_if.ack = force_ack || (mem_if.req && lat != 0 && bn == lat);
    mem_if.dt = mem_fixed ? mem_val : {8'hC0, mem_if.ad};
  end

  function automatic int choose(input logic [2:0] r, input int last);
`ifdef CHRARB_RR_EN
    for (int s = 1; s <= 3; s++) if (r[(last + s) % 3]) return (last + s) % 3;
`else
    for (int c = 0; c < 3; c++) if (r[c]) return c;
    if (last < 0) return -1;
`endif
    return -1;
  endfunction

  // model: one transaction in flight, a dead cycle after each completion
  logic m_busy, m_done, m_err;
  logic [15:0] m_ad;
  logic [2:0] m_rdy;
  logic [23:0] m_dt [3];
  int m_who, m_last, m_n;
  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_err = 0; m_ad = '0; m_rdy = '0;
      m_dt[0] = '0; m_dt[1] = '0; m_dt[2] = '0; m_last = 2; m_n = 0; m_who = 0;
    end else begin
      m_rdy = '0;
      if (m_done) m_done = 0;
      else if (m_busy) begin
        if (mem_if.ack || m_n == TMO) begin
          m_dt[m_who] = mem_if.ack ? mem_if.dt : 24'hFFFFFF;
          if (!mem_if.ack) m_err = 1;
          m_rdy[m_who] = 1'b1;
          m_busy = 0;
          m_done = 1;
        end else m_n++;
      end else if (req != 0) begin
        m_who = choose(req, m_last);
        m_last = m_who;
        m_ad = ad[m_who];
        m_n = 0;
        m_busy = 1;
      end
    end
    #1;
    chk("mem_req", 32'(mem_if.req), 32'(m_busy));
    chk("mem_ad", 32'(mem_if.ad), 32'(m_ad));
    chk("rdy", 32'(rdy), 32'(m_rdy));
    chk("dt0", 32'(dt0), 32'(m_dt[0]));
    chk("dt1", 32'(dt1), 32'(m_dt[1]));
    chk("dt2", 32'(dt2), 32'(m_dt[2]));
    chk("err", 32'(err), 32'(m_err));
  end

  task automatic wait_rdy(input int i, input int lim, output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!rdy[i] && n < lim);
  endtask

  task automatic wait_any(input int lim, output int who, output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (rdy == 0 && n < lim);
    who = rdy[0] ? 0 : rdy[1] ? 1 : rdy[2] ? 2 : -1;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; req = '0;
    @(negedge clk); rst = 1'b0;
  endtask

  int n, hi, who;
  int got [6];
  int gap [6];
  int exp_g [6];
  initial begin
    ad[0] = '0; ad[1] = '0; ad[2] = '0;
    mem_if.ack = 1'b0; mem_if.dt = '0;
    @(posedge clk); #1;
    chk("reset_mem_req", 32'(mem_if.req), 32'h0);
    chk("reset_mem_ad", 32'(mem_if.ad), 32'h0);
    chk("reset_rdy", 32'(rdy), 32'h0);
    chk("reset_dt0", 32'(dt0), 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    @(negedge clk); rst = 1'b0;

    @(negedge clk); mem_fixed = 1; mem_val = 24'hABCDEF; lat = 3; ad[0] = 16'h1234; req[0] = 1;
    wait_rdy(0, 20, n);
    chk("single_cycle", 32'(n), 32'd4);
    chk("single_ad", 32'(mem_if.ad), 32'h1234);
    chk("single_dt0", 32'(dt0), 32'hABCDEF);
    chk("single_dt1", 32'(dt1), 32'h0);
    chk("single_dt2", 32'(dt2), 32'h0);
    @(negedge clk); req[0] = 0;
    @(posedge clk); #1;
    chk("single_pulse", 32'(rdy), 32'h0);

    do_reset();
    @(negedge clk); mem_fixed = 0; lat = 2;
    ad[0] = 16'h0100; ad[1] = 16'h0200; ad[2] = 16'h0300; req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      wait_any(20, who, n);
      got[k] = who;
      gap[k] = n;
    end
    @(negedge clk); req = '0;
`ifdef CHRARB_RR_EN
    exp_g = '{0, 1, 2, 0, 1, 2};
`else
    exp_g = '{0, 0, 0, 0, 0, 0};
`endif
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("grant%0d", k), 32'(got[k]), 32'(exp_g[k]));
      chk($sformatf("gap%0d", k), 32'(gap[k]), k == 0 ? 32'd3 : 32'd4);
    end

    do_reset();
    @(negedge clk); lat = 1; ad[1] = 16'h0AAA; req[1] = 1;
    wait_rdy(1, 10, n);
    chk("b2b_first", 32'(n), 32'd2);
    chk("b2b_dt1a", 32'(dt1), 32'hC00AAA);
    @(negedge clk); ad[1] = 16'h0BBB;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!mem_if.req && n < 10);
    chk("b2b_gap", 32'(n), 32'd2);
    chk("b2b_ad", 32'(mem_if.ad), 32'h0BBB);
    wait_rdy(1, 10, n);
    chk("b2b_second", 32'(n), 32'd1);
    chk("b2b_dt1b", 32'(dt1), 32'hC00BBB);
    @(negedge clk); req[1] = 0;

    do_reset();
    @(negedge clk); lat = 0; ad[2] = 16'h2222; req[2] = 1;
    n = 0; hi = 0;
    do begin @(posedge clk); #1; n++; hi += int'(mem_if.req); end while (!rdy[2] && n < 40);
    chk("tmo_cycle", 32'(n), 32'd12);
    chk("tmo_busy", 32'(hi), 32'd11);
    chk("tmo_dt2", 32'(dt2), 32'hFFFFFF);
    chk("tmo_err", 32'(err), 32'h1);
    @(negedge clk); req[2] = 0;
    @(negedge clk); lat = 2; ad[0] = 16'h0042; req[0] = 1;
    wait_rdy(0, 20, n);
    chk("tmo_next", 32'(n), 32'd3);
    chk("tmo_next_dt0", 32'(dt0), 32'hC00042);
    chk("tmo_err_sticky", 32'(err), 32'h1);
    @(negedge clk); req[0] = 0;

    do_reset();
    @(posedge clk); #1;
    chk("err_cleared", 32'(err), 32'h0);
    @(negedge clk); lat = 4; ad[0] = 16'h0777; req[0] = 1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_busy", 32'(mem_if.req), 32'h1);
    @(negedge clk); rst = 1; req[0] = 0;
    @(negedge clk); rst = 0; force_ack = 1; mem_fixed = 1; mem_val = 24'h5A5A5A;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_mem_req", 32'(mem_if.req), 32'h0);
      chk("rst_rdy", 32'(rdy), 32'h0);
      chk("rst_dt0", 32'(dt0), 32'h0);
    end
    @(negedge clk); force_ack = 0; mem_fixed = 0; lat = 1; ad[1] = 16'h0321; req[1] = 1;
    wait_rdy(1, 10, n);
    chk("rst_idle", 32'(n), 32'd2);
    chk("rst_dt1", 32'(dt1), 32'hC00321);
    @(negedge clk); force_ack = 1; mem_fixed = 1; mem_val = 24'h654321; req[1] = 0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("stray_rdy", 32'(rdy), 32'h0);
      chk("stray_dt1", 32'(dt1), 32'hC00321);
    end
    @(negedge clk); force_ack = 0;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
